uart_frame_scheduler: RTL and testbench
=======================================

# uart_frame_scheduler

Sequences the UART-to-coprocessor datapath: assembles received UART bytes into fixed-size frames, dispatches each frame to the coprocessor when it is free, captures the result, and triggers UART transmission only when the transmitter is idle. Sits between the UART core's RX/TX ports and the coprocessor in the top level. It replaces ad-hoc byte counting, and adds a one-frame pending buffer, overrun detection and a partial-frame timeout.

## Interface
Parameters:
- FRAME_BYTES, 16: bytes per frame; frame width is 8*FRAME_BYTES.
- TIMEOUT_CYCLES, 1_033_400: idle cycles before a partial frame is discarded (10 ms at 103.34 MHz).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rx_byte_valid  in  1  one-cycle strobe; rx_byte is valid.
- rx_byte  in  8  received byte.
- cp_busy  in  1  coprocessor cannot accept din.
- cp_din  out  8*FRAME_BYTES  frame to coprocessor.
- cp_din_valid  out  1  one-cycle dispatch pulse.
- cp_dout  in  8*FRAME_BYTES  coprocessor result.
- cp_dout_valid  in  1  one-cycle result strobe.
- tx_busy  in  1  UART TX still sending.
- tx_frame  out  8*FRAME_BYTES  frame to transmit; held until next capture.
- tx_trigger  out  1  one-cycle send pulse.
- frame_count  out  8  completed round trips; wraps 255→0.
- err_overrun  out  1  sticky: a complete frame was dropped.
- err_timeout  out  1  sticky: a partial frame was discarded.
- state  out  2  dispatch FSM state, for LEDs.

## Operation
- Reset: all outputs 0, byte count 0, pending empty, state IDLE. Reset mid-frame discards all buffered data.
- Assembly runs continuously, independent of the FSM. Byte k of a frame lands at bits [8k+7:8k]; the first byte is k=0.
- On the byte with count==FRAME_BYTES-1, the frame is copied to the pending register and count returns to 0.
- If pending is full at that point, the frame is dropped and err_overrun is set. Exception: if pending is consumed in the same cycle, the frame is accepted.
- FSM states: IDLE=0, DISPATCH=1, WAIT_RESULT=2, SEND=3.
  - IDLE→DISPATCH when pending is valid.
  - DISPATCH: while cp_busy=1, hold. When cp_busy=0: pulse cp_din_valid with cp_din=pending, free pending, go to WAIT_RESULT.
  - WAIT_RESULT: on cp_dout_valid, capture cp_dout into tx_frame and go to SEND. cp_dout_valid in any other state is ignored.
  - SEND: while tx_busy=1, hold. When tx_busy=0: pulse tx_trigger, increment frame_count, go to IDLE.
- cp_din holds the last dispatched frame between dispatches.

## Timing
- Final byte strobe at cycle N → pending valid at N+1 → DISPATCH at N+1 → earliest cp_din_valid at N+2.
- cp_dout_valid at cycle M → tx_frame valid at M+1 → earliest tx_trigger at M+1; tx_frame is stable from M+1.
- Back-to-back frames: the next frame may complete while the FSM is in WAIT_RESULT or SEND. It waits in pending; a third frame completing before pending frees raises overrun.
- All pulse outputs are exactly one cycle wide. Error flags clear only on reset.

## Configuration
- UART_SCHED_TIMEOUT_EN defined: a 32-bit idle counter runs while 0<count<FRAME_BYTES and resets on each rx_byte_valid. When it reaches TIMEOUT_CYCLES, count←0 and err_timeout←1.
- UART_SCHED_TIMEOUT_EN undefined: no counter. Partial frames persist indefinitely and err_timeout is tied to 0.

## Structure
- Package uart_sched_pkg: state enum (IDLE, DISPATCH, WAIT_RESULT, SEND), default FRAME_BYTES, and localparams for frame width and byte-count width ($clog2(FRAME_BYTES)).
- One sub-module, uart_frame_assembler: byte shift-in, count, timeout, and frame_done/frame outputs.
- The dispatch FSM, pending register and error flags live in the top of the block.

## Test plan
- Send 16 bytes 0x00..0x0F with cp_busy=0 → cp_din_valid 2 cycles after the last strobe; cp_din[7:0]=0x00 and cp_din[127:120]=0x0F.
- Hold cp_busy=1 for 50 cycles after a frame completes → no cp_din_valid; the pulse comes in the first cycle cp_busy=0; state reads 1 throughout the wait.
- cp_dout_valid with 0xA5 in every byte while tx_busy=1 for 20 cycles → tx_trigger in the first tx_busy=0 cycle, tx_frame=0xA5.., frame_count 0→1.
- Send three frames while the coprocessor never returns a result → first frame dispatched, second pending, third dropped; err_overrun=1.
- With the macro defined and TIMEOUT_CYCLES=100: send 5 bytes, then idle 100 cycles → err_timeout=1; the next 16 bytes form a clean frame starting at byte 0.
- Assert reset while in WAIT_RESULT with 7 bytes buffered → next cycle all outputs are 0 and state is IDLE; a following full frame is processed normally.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and sizing for the UART frame scheduler: dispatch state encoding,
// default frame size and the derived frame and byte-count widths.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DISPATCH    = 2'd1,
        WAIT_RESULT = 2'd2,
        SEND        = 2'd3
    } sched_state_t;

    // Width of a counter that indexes n bytes; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_FRAME_BYTES = 16;
    localparam int DEFAULT_FRAME_W     = 8 * DEFAULT_FRAME_BYTES;
    localparam int DEFAULT_CNT_W       = cnt_width(DEFAULT_FRAME_BYTES);

endpackage

// File: rtl/uart_frame_assembler.sv
// Shifts received bytes into a frame and flags the cycle that completes it.
// UART_SCHED_TIMEOUT_EN adds an idle counter that discards stale partial frames.
module uart_frame_assembler
    import uart_sched_pkg::*;
#(
    parameter int FRAME_BYTES    = DEFAULT_FRAME_BYTES,
    parameter int TIMEOUT_CYCLES = 1_033_400
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_byte_valid,
    input  logic [7:0]               rx_byte,
    output logic                     frame_done,
    output logic [8*FRAME_BYTES-1:0] frame,
    output logic                     timeout_hit
);
    localparam int FRAME_W = 8 * FRAME_BYTES;
    localparam int CNT_W   = cnt_width(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BYTES - 1);

    if (FRAME_BYTES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_frame_assembler: FRAME_BYTES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [CNT_W-1:0]   count;
    logic [FRAME_W-1:0] shift_q;

    // Bytes enter at the top and move down, so byte 0 ends up in bits [7:0]
    // once the final byte is merged in combinationally.
    assign frame_done = rx_byte_valid && (count == LAST);
    assign frame      = {rx_byte, shift_q[FRAME_W-1:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            shift_q <= '0;
        end else if (rx_byte_valid) begin
            shift_q <= {rx_byte, shift_q[FRAME_W-1:8]};
            count   <= (count == LAST) ? '0 : count + 1'b1;
        end else if (timeout_hit) begin
            count <= '0;
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    logic [31:0] idle_cnt;

    assign timeout_hit = (count != '0) && !rx_byte_valid &&
                         (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || rx_byte_valid || count == '0 || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: rtl/uart_frame_scheduler.sv
// Frame scheduler between UART RX/TX and the coprocessor: one-frame pending buffer,
// dispatch FSM and sticky error flags. Timeout behaviour depends on UART_SCHED_TIMEOUT_EN.
module uart_frame_scheduler
    import uart_sched_pkg::*;
#(
    parameter int FRAME_BYTES    = DEFAULT_FRAME_BYTES,
    parameter int TIMEOUT_CYCLES = 1_033_400
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_byte_valid,
    input  logic [7:0]               rx_byte,
    input  logic                     cp_busy,
    output logic [8*FRAME_BYTES-1:0] cp_din,
    output logic                     cp_din_valid,
    input  logic [8*FRAME_BYTES-1:0] cp_dout,
    input  logic                     cp_dout_valid,
    input  logic                     tx_busy,
    output logic [8*FRAME_BYTES-1:0] tx_frame,
    output logic                     tx_trigger,
    output logic [7:0]               frame_count,
    output logic                     err_overrun,
    output logic                     err_timeout,
    output logic [1:0]               state
);
    localparam int FRAME_W = 8 * FRAME_BYTES;

    sched_state_t       state_q;
    logic               frame_done;
    logic               timeout_hit;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] pending_frame;
    logic               pending_valid;
    logic               consume;

    uart_frame_assembler #(
        .FRAME_BYTES   (FRAME_BYTES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_assembler (
        .clk          (clk),
        .reset        (reset),
        .rx_byte_valid(rx_byte_valid),
        .rx_byte      (rx_byte),
        .frame_done   (frame_done),
        .frame        (frame),
        .timeout_hit  (timeout_hit)
    );

    assign consume = (state_q == DISPATCH) && !cp_busy;
    assign state   = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pending_frame <= '0;
            pending_valid <= 1'b0;
            cp_din        <= '0;
            cp_din_valid  <= 1'b0;
            tx_frame      <= '0;
            tx_trigger    <= 1'b0;
            frame_count   <= '0;
            err_overrun   <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            cp_din_valid <= 1'b0;
            tx_trigger   <= 1'b0;
            err_timeout  <= err_timeout | timeout_hit;

            // A full pending slot can still take the new frame if it is dispatched this cycle.
            if (consume) pending_valid <= 1'b0;
            if (frame_done) begin
                if (!pending_valid || consume) begin
                    pending_frame <= frame;
                    pending_valid <= 1'b1;
                end else begin
                    err_overrun <= 1'b1;
                end
            end

            case (state_q)
                IDLE: if (pending_valid || frame_done) state_q <= DISPATCH;
                DISPATCH: if (!cp_busy) begin
                    cp_din       <= pending_frame;
                    cp_din_valid <= 1'b1;
                    state_q      <= WAIT_RESULT;
                end
                // With the transmitter already idle the send fires straight away,
                // so tx_trigger lines up with tx_frame one cycle after the result.
                WAIT_RESULT: if (cp_dout_valid) begin
                    tx_frame <= cp_dout;
                    if (!tx_busy) begin
                        tx_trigger  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= SEND;
                    end
                end
                SEND: if (!tx_busy) begin
                    tx_trigger  <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: table of full round trips plus
// hand-written busy, overrun, timeout and mid-frame reset sequences.
module tb_uart_frame_scheduler;
    import uart_sched_pkg::*;

    localparam int FB = DEFAULT_FRAME_BYTES;
    localparam int FW = DEFAULT_FRAME_W;

    logic          clk;
    logic          reset;
    logic          rx_byte_valid;
    logic [7:0]    rx_byte;
    logic          cp_busy;
    logic [FW-1:0] cp_din;
    logic          cp_din_valid;
    logic [FW-1:0] cp_dout;
    logic          cp_dout_valid;
    logic          tx_busy;
    logic [FW-1:0] tx_frame;
    logic          tx_trigger;
    logic [7:0]    frame_count;
    logic          err_overrun;
    logic          err_timeout;
    logic [1:0]    state;

    uart_frame_scheduler #(
        .FRAME_BYTES   (FB),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_byte_valid(rx_byte_valid),
        .rx_byte      (rx_byte),
        .cp_busy      (cp_busy),
        .cp_din       (cp_din),
        .cp_din_valid (cp_din_valid),
        .cp_dout      (cp_dout),
        .cp_dout_valid(cp_dout_valid),
        .tx_busy      (tx_busy),
        .tx_frame     (tx_frame),
        .tx_trigger   (tx_trigger),
        .frame_count  (frame_count),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] exp_b0;
        logic [7:0] exp_b15;
        logic [7:0] result;
        logic [7:0] exp_count;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int disp_cnt = 0;

    always @(negedge clk) if (cp_din_valid) disp_cnt++;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] model_frame(input logic [7:0] base, input logic [7:0] step);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < FB; k++) f[8*k +: 8] = base + 8'(k) * step;
        return f;
    endfunction

    task automatic send_bytes(input logic [7:0] base, input logic [7:0] step, input int n, input int first_k);
        for (int i = 0; i < n; i++) begin
            rx_byte_valid = 1'b1;
            rx_byte       = base + 8'(first_k + i) * step;
            tick();
        end
        rx_byte_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cp_din"}, cp_din, '0);
        check({tag, "_cp_din_valid"}, cp_din_valid, '0);
        check({tag, "_tx_frame"}, tx_frame, '0);
        check({tag, "_tx_trigger"}, tx_trigger, '0);
        check({tag, "_frame_count"}, frame_count, '0);
        check({tag, "_err_overrun"}, err_overrun, '0);
        check({tag, "_err_timeout"}, err_timeout, '0);
        check({tag, "_state"}, state, '0);
    endtask

    // Called one cycle after the final byte strobe of the frame described by v.
    task automatic finish_round_trip(input vec_t v, input string tag);
        check({tag, "_state_dispatch"}, state, 2'd1);
        check({tag, "_no_early_dispatch"}, cp_din_valid, 1'b0);
        tick();
        check({tag, "_cp_din_valid"}, cp_din_valid, 1'b1);
        check({tag, "_cp_din"}, cp_din, model_frame(v.base, v.step));
        check({tag, "_cp_din_b0"}, cp_din[7:0], v.exp_b0);
        check({tag, "_cp_din_b15"}, cp_din[FW-1 -: 8], v.exp_b15);
        cp_dout       = {FB{v.result}};
        cp_dout_valid = 1'b1;
        tick();
        cp_dout_valid = 1'b0;
        check({tag, "_din_pulse_width"}, cp_din_valid, 1'b0);
        check({tag, "_tx_trigger"}, tx_trigger, 1'b1);
        check({tag, "_tx_frame"}, tx_frame, {FB{v.result}});
        check({tag, "_frame_count"}, frame_count, v.exp_count);
        tick();
        check({tag, "_trigger_width"}, tx_trigger, 1'b0);
        check({tag, "_state_idle"}, state, 2'd0);
        check({tag, "_err_overrun"}, err_overrun, 1'b0);
    endtask

    task automatic round_trip(input vec_t v, input string tag);
        send_bytes(v.base, v.step, FB, 0);
        finish_round_trip(v, tag);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vec_t vecs[4];
        vec_t v;
        int   d0;

        vecs[0] = '{8'h00, 8'h01, 8'h00, 8'h0F, 8'hA5, 8'd1};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'h5A, 8'd2};
        vecs[2] = '{8'h10, 8'h11, 8'h10, 8'h0F, 8'h3C, 8'd3};
        vecs[3] = '{8'h80, 8'h00, 8'h80, 8'h80, 8'hFF, 8'd4};

        reset         = 1'b1;
        rx_byte_valid = 1'b0;
        rx_byte       = '0;
        cp_busy       = 1'b0;
        cp_dout       = '0;
        cp_dout_valid = 1'b0;
        tx_busy       = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 4; i++) round_trip(vecs[i], $sformatf("vec%0d", i));

        // Coprocessor busy for 50 cycles after the frame completes.
        cp_busy = 1'b1;
        send_bytes(8'h40, 8'h01, FB, 0);
        for (int i = 0; i < 50; i++) begin
            check("busy_hold_state", state, 2'd1);
            check("busy_hold_no_pulse", cp_din_valid, 1'b0);
            tick();
        end
        cp_busy = 1'b0;
        tick();
        check("busy_release_pulse", cp_din_valid, 1'b1);
        check("busy_release_din", cp_din, model_frame(8'h40, 8'h01));
        tick();
        check("busy_release_width", cp_din_valid, 1'b0);

        // Transmitter busy for 20 cycles after the result arrives.
        tx_busy       = 1'b1;
        cp_dout       = {FB{8'hA5}};
        cp_dout_valid = 1'b1;
        tick();
        cp_dout_valid = 1'b0;
        cp_dout       = '0;
        for (int i = 0; i < 20; i++) begin
            check("txbusy_state", state, 2'd3);
            check("txbusy_no_trigger", tx_trigger, 1'b0);
            check("txbusy_tx_frame", tx_frame, {FB{8'hA5}});
            check("txbusy_count_before", frame_count, 8'd4);
            tick();
        end
        tx_busy = 1'b0;
        tick();
        check("txbusy_trigger", tx_trigger, 1'b1);
        check("txbusy_count_after", frame_count, 8'd5);
        tick();
        check("txbusy_trigger_width", tx_trigger, 1'b0);

        // Three frames with no result: first dispatched, second pending, third dropped.
        apply_reset();
        d0 = disp_cnt;
        send_bytes(8'h01, 8'h01, FB, 0);
        tick();
        tick();
        check("ovr_state_wait", state, 2'd2);
        send_bytes(8'h21, 8'h01, FB, 0);
        check("ovr_no_err_second", err_overrun, 1'b0);
        send_bytes(8'h41, 8'h01, FB, 0);
        check("ovr_err_third", err_overrun, 1'b1);
        check("ovr_one_dispatch", 32'(disp_cnt - d0), 32'd1);
        check("ovr_cp_din_held", cp_din, model_frame(8'h01, 8'h01));
        cp_dout       = {FB{8'h11}};
        cp_dout_valid = 1'b1;
        tick();
        cp_dout_valid = 1'b0;
        check("ovr_trigger", tx_trigger, 1'b1);
        tick();
        check("ovr_state_dispatch2", state, 2'd1);
        tick();
        check("ovr_dispatch2", cp_din_valid, 1'b1);
        check("ovr_din2_is_second", cp_din, model_frame(8'h21, 8'h01));
        check("ovr_sticky", err_overrun, 1'b1);

        apply_reset();
        send_bytes(8'h00, 8'h01, 5, 0);
`ifdef UART_SCHED_TIMEOUT_EN
        for (int i = 0; i < 99; i++) tick();
        check("timeout_not_yet", err_timeout, 1'b0);
        tick();
        check("timeout_set", err_timeout, 1'b1);
        v = '{8'h20, 8'h01, 8'h20, 8'h2F, 8'h77, 8'd1};
        round_trip(v, "after_timeout");
        check("timeout_sticky", err_timeout, 1'b1);
`else
        for (int i = 0; i < 150; i++) tick();
        check("no_timeout", err_timeout, 1'b0);
        check("partial_no_dispatch", state, 2'd0);
        send_bytes(8'h00, 8'h01, FB - 5, 5);
        v = '{8'h00, 8'h01, 8'h00, 8'h0F, 8'h77, 8'd1};
        finish_round_trip(v, "partial_kept");
`endif

        // Reset while waiting for a result with 7 bytes of the next frame buffered.
        apply_reset();
        send_bytes(8'h30, 8'h01, FB, 0);
        tick();
        tick();
        check("rst_state_wait", state, 2'd2);
        send_bytes(8'h99, 8'h01, 7, 0);
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        v = '{8'h50, 8'h03, 8'h50, 8'h7D, 8'hC3, 8'd1};
        round_trip(v, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
